// File: rtl/idli_pkg.sv
// -----------------------------------------------------------------------------
// idli_pkg -- shared types for the idli core.
//   ctr_t       : 2-bit core sync counter (value 3 = last GCK of a period)
//   slice_t     : 4-bit datapath nibble
//   urx_state_t : UART receiver framer states
// No ports (package).
// -----------------------------------------------------------------------------
package idli_pkg;

    typedef logic [1:0] ctr_t;
    typedef logic [3:0] slice_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } urx_state_t;

    localparam ctr_t CTR_LAST = 2'd3;

endpackage

// File: rtl/idli_urx_m_if.sv
// -----------------------------------------------------------------------------
// idli_urx_m_if -- bundle of the UART receiver consumer/line signals.
//   ctr  : core sync counter
//   rx   : serial RX line (idle high)
//   data : nibble of the presented word for the current ctr
//   vld  : a word is presented this period
//   acp  : consumer accepts the word (only meaningful at ctr == 3)
// master drives line/counter/accept and observes the word;
// slave is the receiver side.
// -----------------------------------------------------------------------------
interface idli_urx_m_if;
    import idli_pkg::*;

    ctr_t   ctr;
    logic   rx;
    slice_t data;
    logic   vld;
    logic   acp;

    modport master (output ctr, rx, acp, input data, vld);
    modport slave  (input ctr, rx, acp, output data, vld);

endinterface

// File: rtl/idli_urx_m.sv
// -----------------------------------------------------------------------------
// idli_urx_m -- serial UART receiver delivering 16-bit words as nibbles.
// Frames are start(0), 8 data bits LSB first, stop(1), one bit per GCK.
// Two good bytes form a word (first byte low). A completed word goes into a
// one-entry buffer and is presented for whole 4-GCK periods, one nibble per
// counter value.
//
// Ports:
//   i_urx_gck  : core clock
//   i_urx_rst  : synchronous active-high reset
//   i_urx_ctr  : core sync counter, 3 = last GCK of the period
//   i_urx_data : serial RX line, idle high
//   o_urx_data : buffer nibble selected by i_urx_ctr
//   o_urx_vld  : word presented this period
//   i_urx_acp  : consumer accept, sampled only when i_urx_ctr == 3
//   o_urx_err  : sticky framing/overrun flag (only with IDLI_URX_ERR_EN)
//
// Build option: define IDLI_URX_ERR_EN to add o_urx_err.
// -----------------------------------------------------------------------------
module idli_urx_m
    import idli_pkg::*;
(
    input  logic   i_urx_gck,
    input  logic   i_urx_rst,
    input  ctr_t   i_urx_ctr,
    input  logic   i_urx_data,
    output slice_t o_urx_data,
    output logic   o_urx_vld,
    input  logic   i_urx_acp
`ifdef IDLI_URX_ERR_EN
    ,
    output logic   o_urx_err
`endif
);

    urx_state_t  state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  lo_byte_q;
    logic        byte_cnt_q;
    logic [15:0] buf_q;
    logic        full_q;
    logic        full_d;
    logic        pres_q;

    logic        byte_ok;
    logic        frame_err;
    logic        word_done;
    logic        accept;
    logic        load;

    always_comb begin
        byte_ok   = (state_q == STOP) &  i_urx_data;
        frame_err = (state_q == STOP) & ~i_urx_data;
        word_done = byte_ok & byte_cnt_q;
        accept    = (i_urx_ctr == CTR_LAST) & pres_q & i_urx_acp;
        // An accept on the same edge frees the slot for the incoming word.
        load      = word_done & (~full_q | accept);
        full_d    = full_q;
        if (load) begin
            full_d = 1'b1;
        end else if (accept) begin
            full_d = 1'b0;
        end
    end

    // Framer FSM plus buffer/presentation control.
    always_ff @(posedge i_urx_gck) begin
        if (i_urx_rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 1'b0;
            full_q     <= 1'b0;
            pres_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (!i_urx_data) state_q <= DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_q <= STOP;
                STOP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // A bad stop bit also discards a pending low byte.
            if (frame_err) begin
                byte_cnt_q <= 1'b0;
            end else if (byte_ok) begin
                byte_cnt_q <= ~byte_cnt_q;
            end

            full_q <= full_d;
            // Presentation only changes at period boundaries.
            if (i_urx_ctr == CTR_LAST) begin
                pres_q <= full_d;
            end
        end
    end

    // Datapath registers carry no reset; their contents are qualified by
    // the control state above.
    always_ff @(posedge i_urx_gck) begin
        if (state_q == IDLE) begin
            bit_cnt_q <= '0;
        end else if (state_q == DATA) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (state_q == DATA) begin
            shift_q <= {i_urx_data, shift_q[7:1]};
        end
        if (byte_ok && !byte_cnt_q) begin
            lo_byte_q <= shift_q;
        end
        if (load) begin
            buf_q <= {shift_q, lo_byte_q};
        end
    end

    assign o_urx_data = buf_q[{i_urx_ctr, 2'b00} +: 4];
    assign o_urx_vld  = pres_q;

`ifdef IDLI_URX_ERR_EN
    logic overrun;
    logic err_q;

    assign overrun = word_done & full_q & ~accept;

    always_ff @(posedge i_urx_gck) begin
        if (i_urx_rst) begin
            err_q <= 1'b0;
        end else if (frame_err | overrun) begin
            err_q <= 1'b1;
        end
    end

    assign o_urx_err = err_q;
`endif

endmodule

// File: tb/tb_idli_urx_m.sv
module tb_idli_urx_m;
    import idli_pkg::*;

    logic gck = 1'b0;
    logic rst;
    idli_urx_m_if ifc();
`ifdef IDLI_URX_ERR_EN
    logic err;
`endif

    idli_urx_m dut (
        .i_urx_gck  (gck),
        .i_urx_rst  (rst),
        .i_urx_ctr  (ifc.ctr),
        .i_urx_data (ifc.rx),
        .o_urx_data (ifc.data),
        .o_urx_vld  (ifc.vld),
        .i_urx_acp  (ifc.acp)
`ifdef IDLI_URX_ERR_EN
        ,
        .o_urx_err  (err)
`endif
    );

    always #5 gck = ~gck;

    int checks   = 0;
    int failures = 0;
    bit rand_acp = 1'b0;

    // Transaction-level reference: bytes announced by the sender at their
    // stop-bit edge, paired into words and pushed through a 1-deep buffer.
    bit          ev_stop = 1'b0;
    bit          ev_ok   = 1'b0;
    logic [7:0]  ev_byte = '0;
    bit          m_full, m_pres, m_err, m_have_lo;
    logic [7:0]  m_lo;
    logic [15:0] m_word;

    function automatic void model_edge();
        bit          acc;
        bit          done;
        logic [15:0] w;
        if (rst) begin
            m_full = 0; m_pres = 0; m_err = 0; m_have_lo = 0;
            return;
        end
        acc  = (ifc.ctr == 2'd3) && m_pres && ifc.acp;
        done = 0;
        w    = '0;
        if (ev_stop) begin
            if (!ev_ok) begin
                m_have_lo = 0;
                m_err     = 1;
            end else if (!m_have_lo) begin
                m_lo      = ev_byte;
                m_have_lo = 1;
            end else begin
                w         = {ev_byte, m_lo};
                done      = 1;
                m_have_lo = 0;
            end
        end
        if (done) begin
            if (!m_full || acc) begin
                m_word = w;
                m_full = 1;
            end else begin
                m_err = 1;
            end
        end else if (acc) begin
            m_full = 0;
        end
        if (ifc.ctr == 2'd3) m_pres = m_full;
    endfunction

    task automatic tick();
        @(posedge gck);
        model_edge();
        ev_stop = 0;
        #1;
        ifc.ctr = ctr_t'(ifc.ctr + 2'd1);
        if (rand_acp) ifc.acp = ($urandom_range(0, 3) == 0);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop, input bit acp_at_stop);
        logic saved;
        ifc.rx = 1'b0;
        tick();
        for (int unsigned i = 0; i < 8; i++) begin
            ifc.rx = b[i];
            tick();
        end
        saved = ifc.acp;
        if (acp_at_stop) ifc.acp = 1'b1;
        ifc.rx  = stop;
        ev_stop = 1; ev_ok = stop; ev_byte = b;
        tick();
        ifc.acp = saved;
        ifc.rx  = 1'b1;
    endtask

    task automatic wait_present(output bit got);
        got = 0;
        for (int i = 0; i < 64; i++) begin
            if (ifc.vld === 1'b1 && ifc.ctr == 2'd0) begin
                got = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic align(input ctr_t c);
        for (int i = 0; i < 4 && ifc.ctr != c; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1; ifc.rx = 1; ifc.acp = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; ifc.rx = 1; ifc.acp = 0; ifc.ctr = '0;
        repeat (3) tick();
        rst = 0;
        checks++;
        if (ifc.vld !== 1'b0) begin
            failures++; $display("FAIL reset_vld: got %b want 0", ifc.vld);
        end
`ifdef IDLI_URX_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL reset_err: got %b want 0", err);
        end
`endif
    endtask

    task automatic test_basic();
        bit          got;
        logic [15:0] exp = 16'h1234;
        ifc.acp = 1;
        send_byte(8'h34, 1, 0);
        send_byte(8'h12, 1, 0);
        wait_present(got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL basic_timeout: got no vld want vld");
        end
        for (int unsigned k = 0; k < 4; k++) begin
            checks++;
            if (ifc.vld !== 1'b1 || ifc.data !== exp[4*k +: 4]) begin
                failures++;
                $display("FAIL basic_nibble%0d: got vld=%b data=%h want vld=1 data=%h",
                         k, ifc.vld, ifc.data, exp[4*k +: 4]);
            end
            tick();
        end
        checks++;
        if (ifc.vld !== 1'b0) begin
            failures++; $display("FAIL basic_after_acp: got vld=%b want 0", ifc.vld);
        end
    endtask

    task automatic test_backpressure();
        bit          got;
        logic [15:0] exp = 16'hBEEF;
        ifc.acp = 0;
        send_byte(8'hEF, 1, 0);
        send_byte(8'hBE, 1, 0);
        wait_present(got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL bp_timeout: got no vld want vld");
        end
        for (int unsigned p = 0; p < 4; p++) begin
            ifc.acp = (p == 3);
            for (int unsigned k = 0; k < 4; k++) begin
                checks++;
                if (ifc.vld !== 1'b1 || ifc.data !== exp[4*k +: 4]) begin
                    failures++;
                    $display("FAIL bp_p%0d_n%0d: got vld=%b data=%h want vld=1 data=%h",
                             p, k, ifc.vld, ifc.data, exp[4*k +: 4]);
                end
                tick();
            end
        end
        checks++;
        if (ifc.vld !== 1'b0) begin
            failures++; $display("FAIL bp_released: got vld=%b want 0", ifc.vld);
        end
    endtask

    task automatic test_frame_err();
        bit          got;
        logic [15:0] exp = 16'h0001;
        ifc.acp = 1;
        send_byte(8'h55, 1, 0);
        send_byte(8'hAA, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (ifc.vld !== 1'b0) begin
                failures++; $display("FAIL ferr_novld: got vld=%b want 0", ifc.vld);
            end
        end
        send_byte(8'h01, 1, 0);
        send_byte(8'h00, 1, 0);
        wait_present(got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL ferr_timeout: got no vld want vld");
        end
        for (int unsigned k = 0; k < 4; k++) begin
            checks++;
            if (ifc.vld !== 1'b1 || ifc.data !== exp[4*k +: 4]) begin
                failures++;
                $display("FAIL ferr_nibble%0d: got vld=%b data=%h want vld=1 data=%h",
                         k, ifc.vld, ifc.data, exp[4*k +: 4]);
            end
            tick();
        end
`ifdef IDLI_URX_ERR_EN
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL ferr_err: got %b want 1", err);
        end
`endif
    endtask

    task automatic test_overrun();
        bit          got;
        logic [15:0] exp = 16'h1111;
        do_reset();
        ifc.acp = 0;
        send_byte(8'h11, 1, 0);
        send_byte(8'h11, 1, 0);
        wait_present(got);
        send_byte(8'h22, 1, 0);
        send_byte(8'h22, 1, 0);
        repeat (4) tick();
        align(2'd0);
        checks++;
        if (!got) begin
            failures++; $display("FAIL ovr_timeout: got no vld want vld");
        end
        for (int unsigned k = 0; k < 4; k++) begin
            checks++;
            if (ifc.vld !== 1'b1 || ifc.data !== exp[4*k +: 4]) begin
                failures++;
                $display("FAIL ovr_held%0d: got vld=%b data=%h want vld=1 data=%h",
                         k, ifc.vld, ifc.data, exp[4*k +: 4]);
            end
            tick();
        end
`ifdef IDLI_URX_ERR_EN
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL ovr_err: got %b want 1", err);
        end
`endif
        ifc.acp = 1;
        repeat (4) tick();
        checks++;
        if (ifc.vld !== 1'b0) begin
            failures++; $display("FAIL ovr_dropped: got vld=%b want 0", ifc.vld);
        end
    endtask

    task automatic test_accept_and_complete();
        bit          got;
        logic [15:0] exp = 16'h5A5A;
        do_reset();
        ifc.acp = 0;
        send_byte(8'hA5, 1, 0);
        send_byte(8'hA5, 1, 0);
        wait_present(got);
        send_byte(8'h5A, 1, 0);
        // Start when ctr == 2 so the 10th edge (stop bit) lands on ctr == 3.
        align(2'd2);
        checks++;
        if (!got || ifc.vld !== 1'b1 || ifc.data !== 4'h5) begin
            failures++;
            $display("FAIL aac_before: got vld=%b data=%h want vld=1 data=5", ifc.vld, ifc.data);
        end
        send_byte(8'h5A, 1, 1);
        for (int unsigned k = 0; k < 4; k++) begin
            checks++;
            if (ifc.vld !== 1'b1 || ifc.data !== exp[4*k +: 4]) begin
                failures++;
                $display("FAIL aac_nibble%0d: got vld=%b data=%h want vld=1 data=%h",
                         k, ifc.vld, ifc.data, exp[4*k +: 4]);
            end
            tick();
        end
        ifc.acp = 1;
        repeat (4) tick();
        checks++;
        if (ifc.vld !== 1'b0) begin
            failures++; $display("FAIL aac_drain: got vld=%b want 0", ifc.vld);
        end
    endtask

    task automatic test_reset_midframe();
        bit          got;
        logic [15:0] exp = 16'h3412;
        ifc.acp = 1;
        ifc.rx  = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            ifc.rx = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1; ifc.rx = 1;
        tick();
        rst = 0;
        checks++;
        if (ifc.vld !== 1'b0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL rstmid_state: got vld=%b state=%0d want vld=0 state=%0d",
                     ifc.vld, dut.state_q, IDLE);
        end
        send_byte(8'h12, 1, 0);
        send_byte(8'h34, 1, 0);
        wait_present(got);
        checks++;
        if (!got) begin
            failures++; $display("FAIL rstmid_timeout: got no vld want vld");
        end
        for (int unsigned k = 0; k < 4; k++) begin
            checks++;
            if (ifc.vld !== 1'b1 || ifc.data !== exp[4*k +: 4]) begin
                failures++;
                $display("FAIL rstmid_nibble%0d: got vld=%b data=%h want vld=1 data=%h",
                         k, ifc.vld, ifc.data, exp[4*k +: 4]);
            end
            tick();
        end
    endtask

    typedef struct {
        logic       rx;
        bit         ev;
        bit         ok;
        logic [7:0] b;
    } line_bit_t;

    task automatic test_random();
        line_bit_t  sched[$];
        logic [7:0] b;
        bit         ok;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            sched.push_back('{1'b0, 1'b0, 1'b0, 8'h00});
            for (int unsigned i = 0; i < 8; i++) sched.push_back('{b[i], 1'b0, 1'b0, 8'h00});
            sched.push_back('{ok, 1'b1, ok, b});
            repeat ($urandom_range(0, 6)) sched.push_back('{1'b1, 1'b0, 1'b0, 8'h00});
        end
        repeat (12) sched.push_back('{1'b1, 1'b0, 1'b0, 8'h00});
        rand_acp = 1;
        foreach (sched[i]) begin
            ifc.rx  = sched[i].rx;
            ev_stop = sched[i].ev;
            ev_ok   = sched[i].ok;
            ev_byte = sched[i].b;
            tick();
            checks++;
            if (ifc.vld !== m_pres) begin
                failures++; $display("FAIL rand_vld[%0d]: got %b want %b", i, ifc.vld, m_pres);
            end
            if (m_pres) begin
                checks++;
                if (ifc.data !== m_word[{ifc.ctr, 2'b00} +: 4]) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, ifc.data,
                             m_word[{ifc.ctr, 2'b00} +: 4]);
                end
            end
        end
        rand_acp = 0;
        ifc.rx   = 1;
`ifdef IDLI_URX_ERR_EN
        checks++;
        if (err !== m_err) begin
            failures++; $display("FAIL rand_err: got %b want %b", err, m_err);
        end
`endif
    endtask

    initial begin
        ifc.ctr = '0;
        ifc.rx  = 1'b1;
        ifc.acp = 1'b0;
        rst     = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_frame_err();
        test_overrun();
        test_accept_and_complete();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
